// File: rtl/alu_result_stage.sv
// alu_result_stage: registered execute/writeback boundary after the 16-bit ALU.
// It owns the architected flag register (C,N,V,Z) and resolves branches.
// Results go into a two-entry skid FIFO that feeds the register-file write port.
// Optional feature macro: ALU_RESULT_STICKY_V_EN adds a sticky overflow bit
// (sticky_v) and its clear input (sticky_clr).
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [WIDTH-1:0] in_q,
  input  logic [3:0]       in_flags,
  input  logic             in_flag_en,
  input  logic [2:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_rd,
  output logic             out_we,
  output logic [3:0]       flags,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_target
`ifdef ALU_RESULT_STICKY_V_EN
  ,
  input  logic             sticky_clr,
  output logic             sticky_v
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] F_JMP = 4'b0000;
  localparam logic [3:0] F_MOV = 4'b1010;
  localparam logic [3:0] F_BEQ = 4'b1011;
  localparam logic [3:0] F_BNE = 4'b1100;
  localparam logic [3:0] F_BLT = 4'b1101;
  localparam logic [3:0] F_BGT = 4'b1110;
  localparam logic [3:0] F_CMP = 4'b1111;

  // Occupancy of the result buffer; the encoding equals the entry count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } cnt_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       rd;
    logic             we;
  } entry_t;

  // Functions that write a destination register: ADD..LD (0001-1000) and MOV.
  function automatic logic writes_rf(input logic [3:0] f);
    return ((f >= 4'd1) && (f <= 4'd8)) || (f == F_MOV);
  endfunction

  // Branch condition, evaluated against the flags held before the accept.
  function automatic logic branch_taken(input logic [3:0] f, input logic z, input logic n);
    logic t;
    t = 1'b0;
    case (f)
      F_JMP:   t = 1'b1;
      F_BEQ:   t = z;
      F_BNE:   t = ~z;
      F_BLT:   t = n & ~z;
      F_BGT:   t = ~n & ~z;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  cnt_t             cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [3:0]       flags_q;
  logic             br_taken_q;
  logic [WIDTH-1:0] br_target_q;
  logic             accept, pop, flag_upd, take;

  assign in_ready  = (cnt_q != S_FULL);
  assign out_valid = (cnt_q != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign flag_upd  = accept & (in_flag_en | (in_func == F_CMP));
  assign take      = accept & branch_taken(in_func, flags_q[0], flags_q[2]);

  // Head entry is gated so the outputs read zero whenever the buffer is empty.
  assign head      = mem_q[rptr_q];
  assign out_data  = out_valid ? head.data : '0;
  assign out_rd    = out_valid ? head.rd   : '0;
  assign out_we    = out_valid & head.we;

  assign flags     = flags_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;

  // Occupancy state register and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= S_EMPTY;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)    rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  // Occupancy next state: accept and pop together in ONE keeps one entry,
  // and the freshly written entry becomes the head.
  always_comb begin
    cnt_d = cnt_q;
    case (cnt_q)
      S_EMPTY: if (accept) cnt_d = S_ONE;
      S_ONE: begin
        if (accept && !pop)      cnt_d = S_FULL;
        else if (!accept && pop) cnt_d = S_EMPTY;
      end
      S_FULL:  if (pop) cnt_d = S_ONE;
      default: cnt_d = S_EMPTY;
    endcase
  end

  // Result storage; contents are qualified by the occupancy, so no reset.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= '{data: in_q, rd: in_rd, we: writes_rf(in_func)};
  end

  // Architected flags and the one-cycle branch pulse with its target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= 4'b0000;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      if (flag_upd) flags_q <= in_flags;
      br_taken_q <= take;
      if (take) br_target_q <= in_q;
    end
  end

`ifdef ALU_RESULT_STICKY_V_EN
  logic sticky_q;
  assign sticky_v = sticky_q;

  // Sticky overflow: set by any flag update carrying V=1; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (flag_upd && in_flags[1]) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed steps followed by random traffic,
// checked against a queue-based reference model.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [15:0] in_q;
  logic [3:0]  in_flags;
  logic        in_flag_en;
  logic [2:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_rd;
  logic        out_we;
  logic [3:0]  flags;
  logic        br_taken;
  logic [15:0] br_target;
`ifdef ALU_RESULT_STICKY_V_EN
  logic        sticky_clr;
  logic        sticky_v;
  logic        sticky_m;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  rd;
    logic        we;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  flags_m;
  logic        br_taken_m;
  logic [15:0] br_target_m;

  localparam logic [3:0] ADD = 4'b0001, SUB = 4'b0010, JMP = 4'b0000,
                         BEQ = 4'b1011, BNE = 4'b1100, BLT = 4'b1101,
                         BGT = 4'b1110, CMP = 4'b1111;

  alu_result_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_q       (in_q),
    .in_flags   (in_flags),
    .in_flag_en (in_flag_en),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .flags      (flags),
    .br_taken   (br_taken),
    .br_target  (br_target)
`ifdef ALU_RESULT_STICKY_V_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_v   (sticky_v)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_we(input logic [3:0] f);
    return (f inside {[4'd1:4'd8], 4'd10});
  endfunction

  function automatic logic model_taken(input logic [3:0] f, input logic [3:0] fl);
    // fl = {C, N, V, Z}
    case (f)
      JMP:     return 1'b1;
      BEQ:     return fl[0] == 1'b1;
      BNE:     return fl[0] == 1'b0;
      BLT:     return (fl[2] == 1'b1) && (fl[0] == 1'b0);
      BGT:     return (fl[2] == 1'b0) && (fl[0] == 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    flags_m     = 4'b0000;
    br_taken_m  = 1'b0;
    br_target_m = 16'h0000;
`ifdef ALU_RESULT_STICKY_V_EN
    sticky_m    = 1'b0;
`endif
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_in_ready"},  32'(in_ready),  32'd1);
    chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({pfx, "_out_data"},  32'(out_data),  32'd0);
    chk({pfx, "_out_rd"},    32'(out_rd),    32'd0);
    chk({pfx, "_out_we"},    32'(out_we),    32'd0);
    chk({pfx, "_flags"},     32'(flags),     32'd0);
    chk({pfx, "_br_taken"},  32'(br_taken),  32'd0);
    chk({pfx, "_br_target"}, 32'(br_target), 32'd0);
`ifdef ALU_RESULT_STICKY_V_EN
    chk({pfx, "_sticky_v"},  32'(sticky_v),  32'd0);
`endif
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk({tag, "_out_data"}, 32'(out_data), 32'(mq[0].d));
      chk({tag, "_out_rd"},   32'(out_rd),   32'(mq[0].rd));
      chk({tag, "_out_we"},   32'(out_we),   32'(mq[0].we));
    end
    chk({tag, "_flags"},    32'(flags),    32'(flags_m));
    chk({tag, "_br_taken"}, 32'(br_taken), 32'(br_taken_m));
    if (br_taken_m) chk({tag, "_br_target"}, 32'(br_target), 32'(br_target_m));
`ifdef ALU_RESULT_STICKY_V_EN
    chk({tag, "_sticky_v"}, 32'(sticky_v), 32'(sticky_m));
`endif
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [15:0] q,
                       input logic [3:0] fl, input logic en, input logic [2:0] rd,
                       input logic ordy);
    in_valid   = v;
    in_func    = f;
    in_q       = q;
    in_flags   = fl;
    in_flag_en = en;
    in_rd      = rd;
    out_ready  = ordy;
  endtask

  // One clock: advance the model from the inputs present before the edge,
  // then compare all outputs 1 time unit after the edge.
  task automatic cycle(input string tag);
    logic acc, pop, upd;
    ent_t e;
    acc = in_valid && (mq.size() < 2);
    pop = (mq.size() > 0) && out_ready;
    upd = acc && (in_flag_en || (in_func == CMP));
    e   = '{d: in_q, rd: in_rd, we: model_we(in_func)};
    br_taken_m = acc && model_taken(in_func, flags_m);
    if (br_taken_m) br_target_m = in_q;
`ifdef ALU_RESULT_STICKY_V_EN
    if (upd && in_flags[1]) sticky_m = 1'b1;
    else if (sticky_clr)    sticky_m = 1'b0;
`endif
    if (upd) flags_m = in_flags;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(e);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef ALU_RESULT_STICKY_V_EN
    sticky_clr = 1'b0;
`endif
    drive(1'b0, ADD, 16'h0, 4'h0, 1'b0, 3'd0, 1'b1);
    model_reset();
    #2;
    check_reset_values("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Flag register update rules.
    drive(1'b1, ADD, 16'h0000, 4'b1001, 1'b1, 3'd1, 1'b1);
    cycle("add_en");
    chk("flags_add_en", 32'(flags), 32'h9);
    drive(1'b1, ADD, 16'h0005, 4'b0110, 1'b0, 3'd2, 1'b1);
    cycle("add_noen");
    chk("flags_add_noen", 32'(flags), 32'h9);
    drive(1'b1, CMP, 16'h0007, 4'b0110, 1'b0, 3'd3, 1'b1);
    cycle("cmp");
    chk("flags_cmp", 32'(flags), 32'h6);

    // Branching with Z=1.
    drive(1'b1, ADD, 16'h0000, 4'b0001, 1'b1, 3'd4, 1'b1);
    cycle("setz");
    drive(1'b1, BEQ, 16'h0040, 4'b0000, 1'b0, 3'd0, 1'b1);
    cycle("beq");
    chk("beq_taken", 32'(br_taken), 32'd1);
    chk("beq_target", 32'(br_target), 32'h0040);
    chk("beq_we", 32'(out_we), 32'd0);
    drive(1'b0, ADD, 16'h0000, 4'b0000, 1'b0, 3'd0, 1'b1);
    cycle("beq_after");
    chk("beq_pulse_end", 32'(br_taken), 32'd0);
    drive(1'b1, BNE, 16'h0080, 4'b0000, 1'b0, 3'd0, 1'b1);
    cycle("bne");
    chk("bne_taken", 32'(br_taken), 32'd0);
    drive(1'b0, ADD, 16'h0000, 4'b0000, 1'b0, 3'd0, 1'b1);
    cycle("drain0");

`ifdef ALU_RESULT_STICKY_V_EN
    drive(1'b1, SUB, 16'h0011, 4'b0010, 1'b1, 3'd1, 1'b1);
    cycle("stk_set");
    chk("sticky_set", 32'(sticky_v), 32'd1);
    drive(1'b1, ADD, 16'h0012, 4'b0000, 1'b1, 3'd1, 1'b1);
    cycle("stk_hold");
    chk("sticky_hold", 32'(sticky_v), 32'd1);
    drive(1'b0, ADD, 16'h0000, 4'b0000, 1'b0, 3'd0, 1'b1);
    sticky_clr = 1'b1;
    cycle("stk_clr");
    chk("sticky_clr", 32'(sticky_v), 32'd0);
    drive(1'b1, SUB, 16'h0013, 4'b0010, 1'b1, 3'd1, 1'b1);
    cycle("stk_both");
    chk("sticky_set_wins", 32'(sticky_v), 32'd1);
    sticky_clr = 1'b0;
    drive(1'b0, ADD, 16'h0000, 4'b0000, 1'b0, 3'd0, 1'b1);
    cycle("stk_drain");
`endif

    // Backpressure: three ADDs with the consumer stalled.
    drive(1'b1, ADD, 16'd1, 4'b0000, 1'b0, 3'd1, 1'b0);
    cycle("bp1");
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    drive(1'b1, ADD, 16'd2, 4'b0000, 1'b0, 3'd2, 1'b0);
    cycle("bp2");
    chk("bp_ready_after2", 32'(in_ready), 32'd0);
    drive(1'b1, ADD, 16'd3, 4'b0000, 1'b0, 3'd3, 1'b0);
    cycle("bp3_stall");
    chk("bp_head1", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    cycle("bp_full_pop");
    chk("bp_head2", 32'(out_data), 32'd2);
    cycle("bp_acc3");
    chk("bp_head3", 32'(out_data), 32'd3);
    drive(1'b0, ADD, 16'd0, 4'b0000, 1'b0, 3'd0, 1'b1);
    cycle("bp_drain");
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Accept and pop together from one entry, 20 cycles.
    drive(1'b1, MOVF(), 16'h1000, 4'b0000, 1'b0, 3'd5, 1'b1);
    cycle("sim_fill");
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'($urandom_range(1, 10)), 16'($urandom), 4'($urandom), 1'b0,
            3'($urandom), 1'b1);
      cycle("sim");
      chk("sim_cnt_one", 32'({out_valid, in_ready}), 32'b11);
    end
    drive(1'b0, ADD, 16'd0, 4'b0000, 1'b0, 3'd0, 1'b1);
    cycle("sim_drain");

    // Reset while full discards everything.
    drive(1'b1, ADD, 16'hAAAA, 4'b1111, 1'b1, 3'd6, 1'b0);
    cycle("rf1");
    drive(1'b1, JMP, 16'hBBBB, 4'b0000, 1'b0, 3'd7, 1'b0);
    cycle("rf2");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("rst_mid");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    rst_n = 1'b1;
    drive(1'b1, ADD, 16'h1234, 4'b0000, 1'b0, 3'd2, 1'b0);
    cycle("post_rst");
    chk("post_rst_data", 32'(out_data), 32'h1234);
    drive(1'b0, ADD, 16'd0, 4'b0000, 1'b0, 3'd0, 1'b1);
    cycle("post_rst_drain");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 16'($urandom), 4'($urandom),
            1'($urandom), 3'($urandom), 1'($urandom_range(0, 2) != 0));
`ifdef ALU_RESULT_STICKY_V_EN
      sticky_clr = 1'($urandom_range(0, 7) == 0);
`endif
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [3:0] MOVF();
    return 4'b1010;
  endfunction

endmodule
